// File: rtl/drive_mode_if.sv
// Signal bundle between the debounced car controls and the drive-mode sequencer.
// master = control/stimulus side, slave = drive_mode_ctrl.
interface drive_mode_if #(
  parameter int MILE_W = 16
);
  logic              ms_tick;
  logic              power_on_btn;
  logic              power_off_btn;
  logic              throttle;
  logic              clutch;
  logic              brake;
  logic              reverse;
  logic              power;
  logic [1:0]        state;
  logic              gear_rev;
  logic [MILE_W-1:0] mileage;

  modport master (
    output ms_tick, power_on_btn, power_off_btn, throttle, clutch, brake, reverse,
    input  power, state, gear_rev, mileage
  );

  modport slave (
    input  ms_tick, power_on_btn, power_off_btn, throttle, clutch, brake, reverse,
    output power, state, gear_rev, mileage
  );
endinterface

// File: rtl/drive_mode_ctrl.sv
// Manual-drive sequencer: press-and-hold power-up, instant power-down, driving FSM.
// Optional mileage counter built only when DRIVE_MILEAGE_EN is defined.
//
// state           | meaning
// ST_OFF          | engine unpowered, counting power-on hold ticks
// ST_NOT_STARTING | powered, idle; throttle without clutch stalls
// ST_STARTING     | clutch engaged with throttle, ready to move
// ST_MOVING       | driving; mileage prescaler runs on ms_tick
module drive_mode_ctrl #(
  parameter int HOLD_MS = 1000,
  parameter int MILE_MS = 1000,
  parameter int MILE_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  drive_mode_if.slave  dif
);

  typedef enum logic [1:0] {
    ST_OFF          = 2'b00,
    ST_NOT_STARTING = 2'b01,
    ST_STARTING     = 2'b10,
    ST_MOVING       = 2'b11
  } state_e;

  localparam int HOLD_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);

  if (HOLD_MS < 1 || MILE_MS < 1 || MILE_W < 1) begin : g_bad_param
    $error("drive_mode_ctrl: HOLD_MS, MILE_MS and MILE_W must be >= 1");
  end

  state_e            state_q, state_d;
  logic              power_q, power_d;
  logic              gear_rev_q, gear_rev_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              go_off;

`ifdef DRIVE_MILEAGE_EN
  localparam int PRESC_W = (MILE_MS > 1) ? $clog2(MILE_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(MILE_MS - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [MILE_W-1:0]  mileage_q, mileage_d;
`endif

  always_comb begin
    state_d    = state_q;
    power_d    = power_q;
    gear_rev_d = gear_rev_q;
    hold_cnt_d = hold_cnt_q;
    go_off     = 1'b0;
`ifdef DRIVE_MILEAGE_EN
    presc_d    = presc_q;
    mileage_d  = mileage_q;
`endif

    case (state_q)
      ST_OFF: begin
        gear_rev_d = 1'b0;
        if (dif.power_on_btn && !dif.power_off_btn) begin
          if (dif.ms_tick) begin
            if (hold_cnt_q == HOLD_LAST) begin
              hold_cnt_d = '0;
              power_d    = 1'b1;
              state_d    = ST_NOT_STARTING;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end else begin
          hold_cnt_d = '0;
        end
      end

      ST_NOT_STARTING: begin
        gear_rev_d = dif.reverse;
        if (dif.throttle && !dif.clutch) begin
          go_off = 1'b1;
        end else if (dif.throttle && dif.clutch && !dif.brake) begin
          state_d = ST_STARTING;
        end
      end

      ST_STARTING: begin
        gear_rev_d = dif.reverse;
        if (dif.brake) begin
          state_d = ST_NOT_STARTING;
        end else if (dif.throttle && !dif.clutch) begin
          state_d = ST_MOVING;
        end
      end

      default: begin
        // Gear only re-engages with the clutch down; a change without it is a fault.
        if (dif.clutch) begin
          gear_rev_d = dif.reverse;
        end
        if ((dif.reverse != gear_rev_q) && !dif.clutch) begin
          go_off = 1'b1;
        end else if (dif.brake) begin
          state_d = ST_NOT_STARTING;
        end else if (dif.clutch || !dif.throttle) begin
          state_d = ST_STARTING;
        end
      end
    endcase

`ifdef DRIVE_MILEAGE_EN
    if (state_q == ST_MOVING && dif.ms_tick) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (mileage_q != {MILE_W{1'b1}}) begin
          mileage_d = mileage_q + MILE_W'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
`endif

    if (state_q != ST_OFF && dif.power_off_btn) begin
      go_off = 1'b1;
    end

    // Every path into OFF leaves the block in its reset condition.
    if (go_off) begin
      state_d    = ST_OFF;
      power_d    = 1'b0;
      gear_rev_d = 1'b0;
      hold_cnt_d = '0;
`ifdef DRIVE_MILEAGE_EN
      presc_d    = '0;
      mileage_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_OFF;
      power_q    <= 1'b0;
      gear_rev_q <= 1'b0;
      hold_cnt_q <= '0;
`ifdef DRIVE_MILEAGE_EN
      presc_q    <= '0;
      mileage_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      power_q    <= power_d;
      gear_rev_q <= gear_rev_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef DRIVE_MILEAGE_EN
      presc_q    <= presc_d;
      mileage_q  <= mileage_d;
`endif
    end
  end

  assign dif.power    = power_q;
  assign dif.state    = state_q;
  assign dif.gear_rev = gear_rev_q;
`ifdef DRIVE_MILEAGE_EN
  assign dif.mileage  = mileage_q;
`else
  assign dif.mileage  = '0;
`endif

endmodule

// File: doc/drive_mode_ctrl.md
# drive_mode_ctrl

Manual-drive sequencer for the car simulator. Sequences the engine power on a 1 ms tick: press-and-hold power-up, immediate power-down and the manual driving state machine (not-starting / starting / moving) driven by throttle, clutch, brake and reverse controls. It also reports the driving state and an optional mileage count to the display and LED logic. It sits between the debounced switch/button inputs and the display/LED drivers.

## Interface
- HOLD_MS, 1000, number of ms ticks `power_on_btn` must be held to power up
- MILE_MS, 1000, ms ticks spent in MOVING per mileage increment
- MILE_W, 16, mileage counter width
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- ms_tick  in  1  one-`clk`-wide strobe, once per ms
- power_on_btn  in  1  debounced power-on button, level
- power_off_btn  in  1  debounced power-off button, level
- throttle, clutch, brake, reverse  in  1 each  debounced switches, level
- power  out  1  engine powered
- state  out  2  00 OFF, 01 NOT_STARTING, 10 STARTING, 11 MOVING
- gear_rev  out  1  registered copy of `reverse`, valid while powered, else 0
- mileage  out  MILE_W  distance units since last power-up

## Operation
- Reset (`rst`=0 at a `clk` edge): `power`=0, `state`=OFF, `gear_rev`=0, `mileage`=0, hold and mileage prescaler counters cleared.
- OFF:
  - `hold_cnt` increments on each `ms_tick` while `power_on_btn`=1 and `power_off_btn`=0.
  - If `power_on_btn`=0 or `power_off_btn`=1, `hold_cnt` clears in the same cycle.
  - On the tick where `hold_cnt`=HOLD_MS-1: `power`=1, `state`=NOT_STARTING, `hold_cnt` clears.
- Any powered state: `power_off_btn`=1 sets `state`=OFF and `power`=0, and clears `mileage` and the prescaler. This has highest priority.
- NOT_STARTING, priority order:
  - `throttle`&~`clutch` → OFF (stall).
  - `throttle`&`clutch`&~`brake` → STARTING.
  - Otherwise hold.
- STARTING, priority order:
  - `brake` → NOT_STARTING.
  - `throttle`&~`clutch` → MOVING.
  - Otherwise hold.
- MOVING, priority order:
  - `reverse`≠`gear_rev` while `clutch`=0 → OFF (gear fault).
  - `brake` → NOT_STARTING.
  - `clutch`|~`throttle` → STARTING.
  - Otherwise hold.
- `gear_rev` follows `reverse` each cycle while powered. In MOVING it is updated only when `clutch`=1, so a fault compares against the previously engaged gear.
- Entering OFF by any path clears `mileage`, `gear_rev`, `hold_cnt` and the prescaler.
- `power_on_btn` is ignored while powered.

## Timing
- All outputs are registered. Transitions take effect on the `clk` edge after the inputs are sampled (1-cycle latency).
- Power-up is asserted exactly HOLD_MS `ms_tick`s after the first tick seen with the button held. Releasing the button for one cycle restarts the count.
- Power-down takes one cycle and is independent of `ms_tick`.
- Mileage prescaler counts `ms_tick` only in MOVING.
  - It retains its value when leaving MOVING for STARTING or NOT_STARTING, so partial units accumulate.
  - At MILE_MS-1 it wraps to 0 and `mileage` increments.
  - `mileage` saturates at 2^MILE_W-1 and does not wrap.
- State change and prescaler update on the same tick: the prescaler counts only if the current (pre-edge) state is MOVING.
- Asserting reset mid-operation (any state) returns to the reset values on the next edge. No partial hold count survives.

## Configuration
- `DRIVE_MILEAGE_EN` defined: prescaler and mileage counter are built as described.
- `DRIVE_MILEAGE_EN` undefined: no prescaler or mileage registers exist, `mileage` is tied to 0, and the state machine is unchanged.

## Test plan
Bench settings: HOLD_MS=4, MILE_MS=3, `ms_tick` every 5 `clk`, `DRIVE_MILEAGE_EN` defined.

- Power-up hold: hold `power_on_btn` for 4 ticks → `power`=1, `state`=01 one cycle after the 4th tick. Hold for 3 ticks, release, hold again for 3 ticks → `power` stays 0.
- Simultaneous buttons: hold `power_on_btn`=1 and `power_off_btn`=1 for 10 ticks → `power`=0 throughout. Then, while powered in MOVING, pulse `power_off_btn` → next cycle `state`=00, `mileage`=0.
- Drive sequence: from 01, set `throttle`=1, `clutch`=1 → 10. Drop `clutch` → 11. Hold MOVING for 7 ticks → `mileage`=2. Drop `throttle` → 10.
- Stall: in 01, set `throttle`=1, `clutch`=0 → 00, `power`=0. Brake: in 11 or 10, set `brake`=1 → 01.
- Gear fault: in 11, toggle `reverse` with `clutch`=0 → 00. Repeat with `clutch`=1 → stays 10, `gear_rev` tracks the new value.
- Reset and saturation: assert `rst`=0 mid-hold and in MOVING → all outputs 0 next edge. With MILE_W=2, stay in MOVING for 15 ticks → `mileage`=3 (saturated).
